stim_sweep: RTL and testbench

Hardware stimulus sequencer and response capture for the nine-input, two-output `test` logic block. On `start` it walks a 9-bit thermometer pattern from all-zero to all-one, one bit per step, holding each pattern for a fixed number of cycles. At the end of each step it samples the block's `x` and `y` outputs into a 10-entry log. It is the driving and observing side of the `a..i` / `x,y` interface, and lets the same sweep run on silicon or in a synthesizable self-test wrapper.

---
 rtl/stim_sweep.sv | 141 ++++++++++++++
 tb/tb_stim_sweep.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/stim_sweep.sv
// Thermometer stimulus sweep (10 steps, 9 bits) with x/y response capture.
// Optional expected-value compare is built when STIM_SWEEP_CHECK_EN is defined.
module stim_sweep #(
    parameter int unsigned STEP_CYCLES = 4,
    parameter logic [9:0]  EXP_X       = 10'h000,
    parameter logic [9:0]  EXP_Y       = 10'h000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [8:0] stim,
    input  logic       resp_x,
    input  logic       resp_y,
    output logic       busy,
    output logic       done,
    output logic [9:0] x_log,
    output logic [9:0] y_log,
    output logic       err,
    output logic [3:0] err_step
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [7:0] CNT_LAST  = 8'(STEP_CYCLES - 1);
    localparam logic [3:0] STEP_LAST = 4'd9;

    state_t     state_q, state_d;
    logic [3:0] step_q, step_d;
    logic [7:0] cnt_q, cnt_d;
    logic [8:0] stim_q, stim_d;
    logic [9:0] x_log_q, x_log_d;
    logic [9:0] y_log_q, y_log_d;
    logic       sample;
    logic       accept;

    assign sample = (state_q == S_RUN) && (cnt_q == CNT_LAST);
    assign accept = (state_q == S_IDLE) && start;

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        stim_d  = stim_q;
        x_log_d = x_log_q;
        y_log_d = y_log_q;
        case (state_q)
            S_IDLE: begin
                step_d = 4'd0;
                cnt_d  = 8'd0;
                stim_d = 9'h000;
                // Logs survive in IDLE for readout; only a new sweep wipes them.
                if (start) begin
                    state_d = S_RUN;
                    x_log_d = 10'h000;
                    y_log_d = 10'h000;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + 8'd1;
                if (sample) begin
                    x_log_d[step_q] = resp_x;
                    y_log_d[step_q] = resp_y;
                    cnt_d           = 8'd0;
                    if (step_q == STEP_LAST) begin
                        state_d = S_DONE;
                        stim_d  = 9'h000;
                    end else begin
                        step_d = step_q + 4'd1;
                        stim_d = {stim_q[7:0], 1'b1};
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            step_q  <= 4'd0;
            cnt_q   <= 8'd0;
            stim_q  <= 9'h000;
            x_log_q <= 10'h000;
            y_log_q <= 10'h000;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            stim_q  <= stim_d;
            x_log_q <= x_log_d;
            y_log_q <= y_log_d;
        end
    end

`ifdef STIM_SWEEP_CHECK_EN
    logic       err_q, err_d;
    logic [3:0] err_step_q, err_step_d;
    logic       mismatch;

    assign mismatch = (resp_x != EXP_X[step_q]) || (resp_y != EXP_Y[step_q]);

    always_comb begin
        err_d      = err_q;
        err_step_d = err_step_q;
        if (accept) begin
            err_d      = 1'b0;
            err_step_d = 4'd0;
        end else if (sample && mismatch && !err_q) begin
            // Only the first failing step of a sweep is recorded.
            err_d      = 1'b1;
            err_step_d = step_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q      <= 1'b0;
            err_step_q <= 4'd0;
        end else begin
            err_q      <= err_d;
            err_step_q <= err_step_d;
        end
    end

    assign err      = err_q;
    assign err_step = err_step_q;
`else
    logic unused_exp;
    assign unused_exp = ^{EXP_X, EXP_Y, accept};
    assign err        = 1'b0;
    assign err_step   = 4'd0;
`endif

    assign stim  = stim_q;
    assign busy  = (state_q == S_RUN);
    assign done  = (state_q == S_DONE);
    assign x_log = x_log_q;
    assign y_log = y_log_q;

endmodule

// File: tb/tb_stim_sweep.sv
// Directed bench for stim_sweep: AND/OR response model, STEP_CYCLES of 4 and 1.
module tb_stim_sweep;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start0 = 1'b0, start1 = 1'b0;
    logic force_y0 = 1'b0;

    logic [8:0] stim0, stim1;
    logic       resp_x0, resp_y0, resp_x1, resp_y1;
    logic       busy0, done0, err0, busy1, done1, err1;
    logic [9:0] x_log0, y_log0, x_log1, y_log1;
    logic [3:0] err_step0, err_step1;

    int total = 0;
    int bad = 0;
    int done_cnt0 = 0;

    always #5 clk = ~clk;

    // Block under test model: x = AND of a..i, y = OR of a..i
    assign resp_x0 = &stim0;
    assign resp_y0 = force_y0 ? 1'b0 : |stim0;
    assign resp_x1 = &stim1;
    assign resp_y1 = |stim1;

    stim_sweep #(.STEP_CYCLES(4), .EXP_X(10'h200), .EXP_Y(10'h3FE)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .stim(stim0),
        .resp_x(resp_x0), .resp_y(resp_y0), .busy(busy0), .done(done0),
        .x_log(x_log0), .y_log(y_log0), .err(err0), .err_step(err_step0)
    );

    stim_sweep #(.STEP_CYCLES(1), .EXP_X(10'h200), .EXP_Y(10'h3FE)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .stim(stim1),
        .resp_x(resp_x1), .resp_y(resp_y1), .busy(busy1), .done(done1),
        .x_log(x_log1), .y_log(y_log1), .err(err1), .err_step(err_step1)
    );

    always @(negedge clk) if (done0) done_cnt0++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] therm(input int k);
        logic [9:0] v;
        v = (10'd1 << k) - 10'd1;
        return v[8:0];
    endfunction

    // One sweep on instance 0; optional mid-run start pulse, y fault at step 5, reset at step 6.
    task automatic sweep0(input bit pulse12, input bit fy5, input bit rst6);
        int busy_w;
        int d0;
        logic [9:0] ey;
        logic       e_err;
        logic [3:0] e_step;
        ey = fy5 ? 10'h3DE : 10'h3FE;
`ifdef STIM_SWEEP_CHECK_EN
        e_err  = fy5;
        e_step = fy5 ? 4'd5 : 4'd0;
`else
        e_err  = 1'b0;
        e_step = 4'd0;
`endif
        busy_w = 0;
        d0 = done_cnt0;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int c = 0; c < 40; c++) begin
            force_y0 = fy5 && (c >= 20) && (c < 24);
            if (rst6 && c == 25) begin
                rst_n = 1'b0;
                #1;
                chk("rst_stim", 32'(stim0), 32'h0);
                chk("rst_busy", 32'(busy0), 32'h0);
                chk("rst_xlog", 32'(x_log0), 32'h0);
                chk("rst_ylog", 32'(y_log0), 32'h0);
                tick();
                rst_n = 1'b1;
                tick();
                return;
            end
            chk("run_stim", 32'(stim0), 32'(therm(c / 4)));
            if (busy0) busy_w++;
            if (pulse12 && c == 12) start0 = 1'b1;
            if (c == 13) start0 = 1'b0;
            tick();
        end
        force_y0 = 1'b0;
        chk("busy_width", 32'(busy_w), 32'd40);
        chk("end_busy", 32'(busy0), 32'h0);
        chk("end_done", 32'(done0), 32'h1);
        chk("end_stim", 32'(stim0), 32'h0);
        chk("end_xlog", 32'(x_log0), 32'h200);
        chk("end_ylog", 32'(y_log0), 32'(ey));
        chk("end_err", 32'(err0), 32'(e_err));
        chk("end_errstep", 32'(err_step0), 32'(e_step));
        tick();
        chk("post_done", 32'(done0), 32'h0);
        tick();
        tick();
        chk("done_pulses", 32'(done_cnt0 - d0), 32'd1);
        chk("hold_xlog", 32'(x_log0), 32'h200);
        chk("hold_ylog", 32'(y_log0), 32'(ey));
        chk("hold_err", 32'(err0), 32'(e_err));
    endtask

    initial begin
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("idle_stim", 32'(stim0), 32'h0);
        chk("idle_busy", 32'(busy0), 32'h0);
        chk("idle_done", 32'(done0), 32'h0);
        chk("idle_xlog", 32'(x_log0), 32'h0);
        chk("idle_ylog", 32'(y_log0), 32'h0);
        chk("idle_err", 32'(err0), 32'h0);
        chk("idle_busy1", 32'(busy1), 32'h0);

        sweep0(1'b0, 1'b0, 1'b0);
        sweep0(1'b0, 1'b1, 1'b0);
        sweep0(1'b1, 1'b0, 1'b0);
        sweep0(1'b0, 1'b0, 1'b1);
        sweep0(1'b0, 1'b0, 1'b0);

        // STEP_CYCLES=1: one sample per cycle, done 10 cycles after start
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int c = 0; c < 10; c++) begin
            chk("sc1_busy", 32'(busy1), 32'h1);
            chk("sc1_stim", 32'(stim1), 32'(therm(c)));
            tick();
        end
        chk("sc1_busy_end", 32'(busy1), 32'h0);
        chk("sc1_done", 32'(done1), 32'h1);
        chk("sc1_xlog", 32'(x_log1), 32'h200);
        chk("sc1_ylog", 32'(y_log1), 32'h3FE);
        chk("sc1_err", 32'(err1), 32'h0);
        tick();
        chk("sc1_done_end", 32'(done1), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
